lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: max BUSY cycles without ram_ack before abort.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  load/store request from decode.
REQ-005 SHALL have port req_we  input  1  1=store, 0=load.
REQ-006 SHALL have port req_type  input  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-009 SHALL have port req_rd  input  5  load destination register.
REQ-010 SHALL have port req_ready  output  1  1 only in IDLE.
REQ-011 SHALL have port stall_req  output  1  pipeline hold request.
REQ-012 SHALL have ports ram_req/ram_we  output  1 each  RAM request strobe and write enable.
REQ-013 SHALL have ports ram_addr  output  32  word-aligned address ({req_addr[31:2],2'b00}); ram_be  output  4  byte enables; ram_wdata  output  32  lane-positioned data.
REQ-014 SHALL have ports ram_ack  input  1  RAM completion; ram_rdata  input  32  read word, valid with ram_ack.
REQ-015 SHALL have ports wb_wreg  output  1, wb_waddr  output  5, wb_wdata  output  32  register writeback.
REQ-016 SHALL have ports err_misalign, err_timeout  output  1 each  one-cycle error pulses.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, with all outputs except stall_req registered.
REQ-018 In IDLE, a request SHALL be accepted on req_valid=1; fields latched at that edge.
REQ-019 Misaligned (H: addr[0]=1; W: addr[1:0]!=0) or illegal type (load 011/110/111, store >=011) SHALL pulse err_misalign next cycle, issue no RAM access, no writeback, stay IDLE.
REQ-020 A legal request SHALL go to BUSY; ram_req=1 from the next cycle, addr/we/be/wdata held stable until ram_ack=1 is sampled.
REQ-021 On ram_ack=1 in BUSY: ram_req SHALL drop next cycle, state returns to IDLE; for loads wb_wreg=1 for exactly one cycle with wb_waddr=latched rd.
REQ-022 Minimum latency: accept edge N, ram_req high in N+1, ack at N+1 gives wb_wreg high in N+2.
REQ-023 Loads with rd=0 SHALL perform the RAM access but keep wb_wreg=0.
REQ-024 Byte enables: B 4'b0001<<addr[1:0]; H addr[1]?1100:0011; W 1111; same rule for loads and stores.
REQ-025 ram_wdata: SB byte replicated to all four lanes; SH halfword replicated to both halves; SW unchanged.
REQ-026 Load data: LB/LBU select byte addr[1:0], LH/LHU halfword addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
REQ-027 stall_req SHALL be high combinationally when state=BUSY, or when state=IDLE and req_valid=1 with a legal request.
REQ-028 BUSY cycle counter (8+ bits) SHALL reach TIMEOUT_CYC without ack -> drop ram_req, pulse err_timeout, no writeback, return IDLE.
REQ-029 ram_ack while IDLE SHALL be ignored; req_valid while BUSY SHALL be ignored (not queued).

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, clear counter and latches, and set ram_req, ram_we, ram_be, wb_wreg, err_* to 0, ram_addr/ram_wdata/wb_wdata to 0, wb_waddr to 0.
REQ-031 rst mid-BUSY SHALL abort the access with no writeback and no error pulse.

Verification
REQ-032 LB addr 0x103, ram_rdata 0x80FF_FF00, rd=5, ack immediate -> ram_be 1000, wb_wdata 0xFFFF_FF80, wb_waddr 5, wb in N+2.
REQ-033 SH addr 0x202, wdata 0x0000_ABCD -> ram_addr 0x200, ram_be 1100, ram_wdata 0xABCD_ABCD, wb_wreg stays 0.
REQ-034 LW addr 0x101 -> err_misalign pulse one cycle, ram_req never asserted, stall_req 0.
REQ-035 LHU addr 0x002, ack delayed 5 cycles, rdata 0xBEEF_1234 -> ram_req held 6 cycles, stall_req high throughout, wb_wdata 0x0000_BEEF.
REQ-036 TIMEOUT_CYC=4, no ack -> err_timeout pulse after 4 BUSY cycles, ram_req low, back in IDLE (req_ready=1).
REQ-037 rst asserted during BUSY, then ack -> no writeback, ram_req 0 after reset edge, ack ignored.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: issues one RAM access per request,
// handles byte/halfword lane placement, load extension and access timeout.
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  output logic        stall_req,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic        ram_ack,
  input  logic [31:0] ram_rdata,
  output logic        wb_wreg,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state_r, next_state_s;
  logic [CW-1:0] cnt_r;
  logic          we_r;
  logic [2:0]    type_r;
  logic [1:0]    off_r;
  logic [4:0]    rd_r;
  logic          legal_s, accept_s, bad_s, done_s, timeout_s;

  function automatic logic legal_f(input logic we, input logic [2:0] t, input logic [1:0] a);
    logic ok;
    case (t)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_f(input logic [2:0] t, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = d >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? d[31:16] : d[15:0];
    case (t)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign legal_s   = legal_f(req_we, req_type, req_addr[1:0]);
  // Hold the pipeline as soon as a legal request is seen, not a cycle later.
  assign stall_req = (state_r == BUSY) || (req_valid && legal_s);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // Next-state and event decode; ack takes priority over a coincident timeout.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    bad_s        = 1'b0;
    done_s       = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (legal_s) begin
            accept_s     = 1'b1;
            next_state_s = BUSY;
          end else begin
            bad_s = 1'b1;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (ram_ack) begin
          done_s       = 1'b1;
          next_state_s = IDLE;
        end else if (cnt_r == TO_LAST) begin
          timeout_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = BUSY;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Registered RAM request, writeback and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready    <= 1'b1;
      ram_req      <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= 32'h0000_0000;
      ram_be       <= 4'b0000;
      ram_wdata    <= 32'h0000_0000;
      wb_wreg      <= 1'b0;
      wb_waddr     <= 5'd0;
      wb_wdata     <= 32'h0000_0000;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      cnt_r        <= '0;
      we_r         <= 1'b0;
      type_r       <= 3'b000;
      off_r        <= 2'b00;
      rd_r         <= 5'd0;
    end else begin
      req_ready    <= (next_state_s == IDLE);
      err_misalign <= bad_s;
      err_timeout  <= timeout_s;
      wb_wreg      <= 1'b0;
      if (accept_s) begin
        we_r      <= req_we;
        type_r    <= req_type;
        off_r     <= req_addr[1:0];
        rd_r      <= req_rd;
        cnt_r     <= '0;
        ram_req   <= 1'b1;
        ram_we    <= req_we;
        ram_addr  <= {req_addr[31:2], 2'b00};
        ram_be    <= be_f(req_type[1:0], req_addr[1:0]);
        ram_wdata <= req_we ? wdata_f(req_type[1:0], req_wdata) : 32'h0000_0000;
      end else if (done_s || timeout_s) begin
        ram_req <= 1'b0;
        cnt_r   <= '0;
        if (done_s && !we_r && (rd_r != 5'd0)) begin
          wb_wreg  <= 1'b1;
          wb_waddr <= rd_r;
          wb_wdata <= load_f(type_r, off_r, ram_rdata);
        end else begin
          wb_wreg <= 1'b0;
        end
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: default-timeout instance plus a
// TIMEOUT_CYC=4 instance sharing the same stimulus.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, ram_ack;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata, ram_rdata;
  logic [4:0]  req_rd;

  logic        req_ready, stall_req, ram_req, ram_we, wb_wreg, err_misalign, err_timeout;
  logic [31:0] ram_addr, ram_wdata, wb_wdata;
  logic [3:0]  ram_be;
  logic [4:0]  wb_waddr;

  logic        t_req_ready, t_stall_req, t_ram_req, t_ram_we, t_wb_wreg, t_err_misalign, t_err_timeout;
  logic [31:0] t_ram_addr, t_ram_wdata, t_wb_wdata;
  logic [3:0]  t_ram_be;
  logic [4:0]  t_wb_waddr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd), .req_ready(req_ready),
    .stall_req(stall_req), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .wb_wreg(wb_wreg), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  lsu_mem_ctrl #(.TIMEOUT_CYC(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd), .req_ready(t_req_ready),
    .stall_req(t_stall_req), .ram_req(t_ram_req), .ram_we(t_ram_we), .ram_addr(t_ram_addr),
    .ram_be(t_ram_be), .ram_wdata(t_ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .wb_wreg(t_wb_wreg), .wb_waddr(t_wb_waddr), .wb_wdata(t_wb_wdata),
    .err_misalign(t_err_misalign), .err_timeout(t_err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = wd; req_rd = rd;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 3'b000; req_addr = 32'h0;
    req_wdata = 32'h0; req_rd = 5'd0; ram_ack = 1'b0; ram_rdata = 32'h0;
    step(); step();
    rst = 1'b0;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_ram_req", {31'd0, ram_req}, 32'd0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_be", {28'd0, ram_be}, 32'd0);
    check("rst_wb", {31'd0, wb_wreg}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);

    // LB 0x103, immediate ack
    drive_req(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5);
    #1 check("lb_stall_idle", {31'd0, stall_req}, 32'd1);
    step();
    req_valid = 1'b0;
    check("lb_ram_req", {31'd0, ram_req}, 32'd1);
    check("lb_be", {28'd0, ram_be}, 32'h8);
    check("lb_addr", ram_addr, 32'h0000_0100);
    check("lb_ready_busy", {31'd0, req_ready}, 32'd0);
    check("lb_wb_early", {31'd0, wb_wreg}, 32'd0);
    ram_ack = 1'b1; ram_rdata = 32'h80FF_FF00;
    step();
    ram_ack = 1'b0;
    check("lb_wb", {31'd0, wb_wreg}, 32'd1);
    check("lb_waddr", {27'd0, wb_waddr}, 32'd5);
    check("lb_wdata", wb_wdata, 32'hFFFF_FF80);
    check("lb_ram_req_drop", {31'd0, ram_req}, 32'd0);
    check("lb_ready_back", {31'd0, req_ready}, 32'd1);
    step();
    check("lb_wb_one_cycle", {31'd0, wb_wreg}, 32'd0);

    // SH 0x202
    drive_req(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd0);
    step();
    req_valid = 1'b0;
    check("sh_addr", ram_addr, 32'h0000_0200);
    check("sh_be", {28'd0, ram_be}, 32'hC);
    check("sh_wdata", ram_wdata, 32'hABCD_ABCD);
    check("sh_we", {31'd0, ram_we}, 32'd1);
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    check("sh_no_wb", {31'd0, wb_wreg}, 32'd0);
    check("sh_ram_req_drop", {31'd0, ram_req}, 32'd0);

    // SB 0x001 replicates byte
    drive_req(1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5, 5'd0);
    step();
    req_valid = 1'b0;
    check("sb_be", {28'd0, ram_be}, 32'h2);
    check("sb_wdata", ram_wdata, 32'hA5A5_A5A5);
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;

    // LW misaligned 0x101
    drive_req(1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd4);
    #1 check("mis_stall", {31'd0, stall_req}, 32'd0);
    step();
    req_valid = 1'b0;
    check("mis_err", {31'd0, err_misalign}, 32'd1);
    check("mis_no_req", {31'd0, ram_req}, 32'd0);
    check("mis_ready", {31'd0, req_ready}, 32'd1);
    step();
    check("mis_err_pulse", {31'd0, err_misalign}, 32'd0);
    check("mis_no_req2", {31'd0, ram_req}, 32'd0);

    // Illegal store type 011
    drive_req(1'b1, 3'b011, 32'h0000_0000, 32'h0, 5'd0);
    step();
    req_valid = 1'b0;
    check("ill_err", {31'd0, err_misalign}, 32'd1);
    check("ill_no_req", {31'd0, ram_req}, 32'd0);
    step();

    // LHU 0x002, ack after 5 extra cycles
    drive_req(1'b0, 3'b101, 32'h0000_0002, 32'h0, 5'd7);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("lhu_req_held", {31'd0, ram_req}, 32'd1);
      check("lhu_stall", {31'd0, stall_req}, 32'd1);
      step();
    end
    check("lhu_req_6th", {31'd0, ram_req}, 32'd1);
    check("lhu_be", {28'd0, ram_be}, 32'hC);
    ram_ack = 1'b1; ram_rdata = 32'hBEEF_1234;
    step();
    ram_ack = 1'b0;
    check("lhu_wb", {31'd0, wb_wreg}, 32'd1);
    check("lhu_wdata", wb_wdata, 32'h0000_BEEF);
    check("lhu_waddr", {27'd0, wb_waddr}, 32'd7);
    check("lhu_ram_req_drop", {31'd0, ram_req}, 32'd0);
    check("lhu_t4_no_wb", {31'd0, t_wb_wreg}, 32'd0);
    step();

    // LH sign extension, low half
    drive_req(1'b0, 3'b001, 32'h0000_0010, 32'h0, 5'd2);
    step();
    req_valid = 1'b0;
    ram_ack = 1'b1; ram_rdata = 32'h0000_8001;
    step();
    ram_ack = 1'b0;
    check("lh_wdata", wb_wdata, 32'hFFFF_8001);

    // Load to x0: access happens, no writeback
    drive_req(1'b0, 3'b010, 32'h0000_0030, 32'h0, 5'd0);
    step();
    req_valid = 1'b0;
    check("x0_ram_req", {31'd0, ram_req}, 32'd1);
    ram_ack = 1'b1; ram_rdata = 32'h5555_5555;
    step();
    ram_ack = 1'b0;
    check("x0_no_wb", {31'd0, wb_wreg}, 32'd0);

    // Timeout on the TIMEOUT_CYC=4 instance
    drive_req(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd3);
    step();
    req_valid = 1'b0;
    check("to_req", {31'd0, t_ram_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_req_held", {31'd0, t_ram_req}, 32'd1);
      check("to_no_err_yet", {31'd0, t_err_timeout}, 32'd0);
    end
    step();
    check("to_err", {31'd0, t_err_timeout}, 32'd1);
    check("to_req_drop", {31'd0, t_ram_req}, 32'd0);
    check("to_ready", {31'd0, t_req_ready}, 32'd1);
    check("to_no_wb", {31'd0, t_wb_wreg}, 32'd0);
    check("to_dflt_busy", {31'd0, ram_req}, 32'd1);
    step();
    check("to_err_pulse", {31'd0, t_err_timeout}, 32'd0);
    ram_ack = 1'b1; ram_rdata = 32'h0000_0001;
    step();
    ram_ack = 1'b0;
    check("to_idle_ack_ignored", {31'd0, t_wb_wreg}, 32'd0);
    check("to_dflt_wb", {31'd0, wb_wreg}, 32'd1);

    // Reset during BUSY, then ack
    drive_req(1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd9);
    step();
    req_valid = 1'b0;
    check("rb_busy", {31'd0, ram_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rb_req_cleared", {31'd0, ram_req}, 32'd0);
    check("rb_ready", {31'd0, req_ready}, 32'd1);
    check("rb_no_err", {31'd0, err_timeout}, 32'd0);
    ram_ack = 1'b1; ram_rdata = 32'h1234_5678;
    step();
    ram_ack = 1'b0;
    check("rb_no_wb", {31'd0, wb_wreg}, 32'd0);
    check("rb_no_req", {31'd0, ram_req}, 32'd0);
    check("rb_no_stall", {31'd0, stall_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
